// File: rtl/tl45_wb_pkg.sv
// rtl/tl45_wb_pkg.sv - shared types and owner encodings for the Wishbone arbiter
package tl45_wb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2,
        ABORT   = 2'd3
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_A    = 2'd1;
    localparam logic [1:0] OWN_B    = 2'd2;

endpackage

// File: rtl/tl45_wb_watchdog.sv
// rtl/tl45_wb_watchdog.sv - ack watchdog; pulses o_expire after TIMEOUT_CYCLES stalled cycles
module tl45_wb_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_busy,
    input  logic i_progress,
    output logic o_expire
);

    localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] r_count;

    assign o_expire = i_busy && !i_progress && (r_count == LIMIT);

    always_ff @(posedge i_clk) begin
        if (i_reset || !i_busy || i_progress || o_expire)
            r_count <= '0;
        else
            r_count <= r_count + 1'b1;
    end

endmodule

// File: rtl/tl45_wb_arbiter.sv
// rtl/tl45_wb_arbiter.sv - two-master pipelined Wishbone arbiter with whole-cycle grants
module tl45_wb_arbiter
    import tl45_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int CNT_W           = 4,
    parameter bit OPT_ROUND_ROBIN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_a_cyc,
    input  logic        i_a_stb,
    input  logic        i_a_we,
    input  logic [29:0] i_a_addr,
    input  logic [31:0] i_a_data,
    input  logic [3:0]  i_a_sel,
    output logic        o_a_ack,
    output logic        o_a_stall,
    output logic        o_a_err,
    output logic [31:0] o_a_data,
    input  logic        i_b_cyc,
    input  logic        i_b_stb,
    input  logic        i_b_we,
    input  logic [29:0] i_b_addr,
    input  logic [31:0] i_b_data,
    input  logic [3:0]  i_b_sel,
    output logic        o_b_ack,
    output logic        o_b_stall,
    output logic        o_b_err,
    output logic [31:0] o_b_data,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [29:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall,
    input  logic        i_wb_err,
    input  logic [31:0] i_wb_data,
    output logic [1:0]  o_owner,
    output logic        o_timeout
);

    state_t           r_state, w_next_state;
    logic [1:0]       r_last_owner, w_next_last;
    logic [CNT_W-1:0] r_outstanding, w_next_outstanding;
    logic             w_own_a, w_own_b, w_owner_cyc, w_owner_stb;
    logic             w_full, w_accept, w_progress, w_busy, w_expire;

    // Ownership is masked during reset so nothing is forwarded in that cycle.
    assign w_own_a     = (r_state == GRANT_A) && !i_reset;
    assign w_own_b     = (r_state == GRANT_B) && !i_reset;
    assign w_full      = &r_outstanding;
    assign w_owner_cyc = (w_own_a && i_a_cyc) || (w_own_b && i_b_cyc);
    assign w_owner_stb = (w_own_a && i_a_stb) || (w_own_b && i_b_stb);

    assign o_wb_cyc  = w_owner_cyc;
    assign o_wb_stb  = w_owner_cyc && w_owner_stb && !w_full;
    assign o_wb_we   = w_own_b ? i_b_we   : i_a_we;
    assign o_wb_addr = w_own_b ? i_b_addr : i_a_addr;
    assign o_wb_data = w_own_b ? i_b_data : i_a_data;
    assign o_wb_sel  = w_own_b ? i_b_sel  : i_a_sel;

    assign w_accept   = o_wb_stb && !i_wb_stall;
    assign w_progress = i_wb_ack || i_wb_err;
    assign w_busy     = (w_own_a || w_own_b) && (r_outstanding != '0);

    assign o_a_ack   = w_own_a && i_wb_ack;
    assign o_a_err   = w_own_a && (i_wb_err || w_expire);
    assign o_a_stall = !w_own_a || i_wb_stall || w_full;
    assign o_b_ack   = w_own_b && i_wb_ack;
    assign o_b_err   = w_own_b && (i_wb_err || w_expire);
    assign o_b_stall = !w_own_b || i_wb_stall || w_full;
    assign o_a_data  = i_wb_data;
    assign o_b_data  = i_wb_data;

    assign o_owner   = w_own_a ? OWN_A : (w_own_b ? OWN_B : OWN_NONE);
    assign o_timeout = w_expire;

    tl45_wb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_busy     (w_busy),
        .i_progress (w_progress),
        .o_expire   (w_expire)
    );

    always_comb begin
        w_next_state = r_state;
        w_next_last  = r_last_owner;
        case (r_state)
            IDLE: begin
                if (i_a_cyc && i_b_cyc) begin
                    if (OPT_ROUND_ROBIN && (r_last_owner == OWN_B)) begin
                        w_next_state = GRANT_A;
                        w_next_last  = OWN_A;
                    end else begin
                        w_next_state = GRANT_B;
                        w_next_last  = OWN_B;
                    end
                end else if (i_a_cyc) begin
                    w_next_state = GRANT_A;
                    w_next_last  = OWN_A;
                end else if (i_b_cyc) begin
                    w_next_state = GRANT_B;
                    w_next_last  = OWN_B;
                end
            end
            GRANT_A: begin
                if (w_expire) begin
                    w_next_state = ABORT;
                end else if (!i_a_cyc) begin
                    if (i_b_cyc) begin
                        w_next_state = GRANT_B;
                        w_next_last  = OWN_B;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            GRANT_B: begin
                if (w_expire) begin
                    w_next_state = ABORT;
                end else if (!i_b_cyc) begin
                    if (i_a_cyc) begin
                        w_next_state = GRANT_A;
                        w_next_last  = OWN_A;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            ABORT: begin
                // last_owner still names the master whose cycle was aborted
                if ((r_last_owner == OWN_A) ? !i_a_cyc : !i_b_cyc)
                    w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_next_outstanding = r_outstanding;
        if ((w_next_state != r_state) || !w_owner_cyc) begin
            w_next_outstanding = '0;
        end else begin
            case ({w_accept, w_progress})
                2'b10:   w_next_outstanding = r_outstanding + 1'b1;
                2'b01:   if (r_outstanding != '0) w_next_outstanding = r_outstanding - 1'b1;
                default: w_next_outstanding = r_outstanding;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_last_owner  <= OWN_A;
            r_outstanding <= '0;
        end else begin
            r_state       <= w_next_state;
            r_last_owner  <= w_next_last;
            r_outstanding <= w_next_outstanding;
        end
    end

endmodule

// File: tb/tb_tl45_wb_arbiter.sv
// tb/tb_tl45_wb_arbiter.sv - self-checking bench for the two-master Wishbone arbiter
module tb_tl45_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
    logic [29:0] a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata, wb_rdata;
    logic [3:0]  a_sel, b_sel;
    logic        wb_ack, wb_stall, wb_err;

    logic        o_a_ack, o_a_stall, o_a_err, o_b_ack, o_b_stall, o_b_err;
    logic [31:0] o_a_data, o_b_data, o_wb_data;
    logic        o_wb_cyc, o_wb_stb, o_wb_we, o_timeout;
    logic [29:0] o_wb_addr;
    logic [3:0]  o_wb_sel;
    logic [1:0]  o_owner;

    logic        f_a_ack, f_a_stall, f_a_err, f_b_ack, f_b_stall, f_b_err;
    logic [31:0] f_a_data, f_b_data, f_wb_data;
    logic        f_wb_cyc, f_wb_stb, f_wb_we, f_timeout;
    logic [29:0] f_wb_addr;
    logic [3:0]  f_wb_sel;
    logic [1:0]  f_owner;

    int tests = 0;
    int fails = 0;

    tl45_wb_arbiter #(.TIMEOUT_CYCLES(16), .CNT_W(4), .OPT_ROUND_ROBIN(1'b1)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr),
        .i_a_data(a_wdata), .i_a_sel(a_sel),
        .o_a_ack(o_a_ack), .o_a_stall(o_a_stall), .o_a_err(o_a_err), .o_a_data(o_a_data),
        .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr),
        .i_b_data(b_wdata), .i_b_sel(b_sel),
        .o_b_ack(o_b_ack), .o_b_stall(o_b_stall), .o_b_err(o_b_err), .o_b_data(o_b_data),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
        .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_err(wb_err), .i_wb_data(wb_rdata),
        .o_owner(o_owner), .o_timeout(o_timeout)
    );

    tl45_wb_arbiter #(.TIMEOUT_CYCLES(16), .CNT_W(4), .OPT_ROUND_ROBIN(1'b0)) dut_fp (
        .i_clk(clk), .i_reset(rst),
        .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr),
        .i_a_data(a_wdata), .i_a_sel(a_sel),
        .o_a_ack(f_a_ack), .o_a_stall(f_a_stall), .o_a_err(f_a_err), .o_a_data(f_a_data),
        .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr),
        .i_b_data(b_wdata), .i_b_sel(b_sel),
        .o_b_ack(f_b_ack), .o_b_stall(f_b_stall), .o_b_err(f_b_err), .o_b_data(f_b_data),
        .o_wb_cyc(f_wb_cyc), .o_wb_stb(f_wb_stb), .o_wb_we(f_wb_we), .o_wb_addr(f_wb_addr),
        .o_wb_data(f_wb_data), .o_wb_sel(f_wb_sel),
        .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_err(wb_err), .i_wb_data(wb_rdata),
        .o_owner(f_owner), .o_timeout(f_timeout)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_cyc = 0; a_stb = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_sel = 4'hf;
        b_cyc = 0; b_stb = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_sel = 4'hf;
        wb_ack = 0; wb_stall = 0; wb_err = 0; wb_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
        #1;
        tests++; if (o_wb_cyc !== 1'b0 || o_wb_stb !== 1'b0) begin fails++; $display("FAIL reset_bus cyc=%b stb=%b want 0 0", o_wb_cyc, o_wb_stb); end
        tests++; if (o_owner !== 2'd0) begin fails++; $display("FAIL reset_owner got %0d want 0", o_owner); end
        tests++; if ({o_a_ack, o_a_err, o_b_ack, o_b_err, o_timeout} !== 5'b0) begin fails++; $display("FAIL reset_resp got %b want 00000", {o_a_ack, o_a_err, o_b_ack, o_b_err, o_timeout}); end
        tests++; if (o_a_stall !== 1'b1 || o_b_stall !== 1'b1) begin fails++; $display("FAIL reset_stall a=%b b=%b want 1 1", o_a_stall, o_b_stall); end
    endtask

    task automatic test_a_alone();
        logic [31:0] d;
        do_reset();
        a_cyc = 1; a_stb = 1; a_addr = 30'h100;
        #1;
        tests++; if (o_wb_cyc !== 1'b0 || o_owner !== 2'd0) begin fails++; $display("FAIL a_alone_t0 cyc=%b owner=%0d want 0 0", o_wb_cyc, o_owner); end
        step();
        tests++; if (o_owner !== 2'd1) begin fails++; $display("FAIL a_alone_grant owner=%0d want 1", o_owner); end
        tests++; if (o_wb_addr !== 30'h100 || o_wb_cyc !== 1'b1 || o_wb_stb !== 1'b1) begin fails++; $display("FAIL a_alone_bus addr=%0h cyc=%b stb=%b want 100 1 1", o_wb_addr, o_wb_cyc, o_wb_stb); end
        tests++; if (o_a_stall !== 1'b0 || o_b_stall !== 1'b1) begin fails++; $display("FAIL a_alone_stall a=%b b=%b want 0 1", o_a_stall, o_b_stall); end
        step();
        a_stb = 0;
        #1;
        tests++; if (o_b_stall !== 1'b1) begin fails++; $display("FAIL a_alone_bstall_t2 got %b want 1", o_b_stall); end
        step();
        d = $urandom;
        wb_ack = 1; wb_rdata = d; a_cyc = 0;
        #1;
        tests++; if (o_a_ack !== 1'b1 || o_b_ack !== 1'b0) begin fails++; $display("FAIL a_alone_ack a=%b b=%b want 1 0", o_a_ack, o_b_ack); end
        tests++; if (o_a_data !== d || o_b_data !== d) begin fails++; $display("FAIL a_alone_data a=%0h b=%0h want %0h", o_a_data, o_b_data, d); end
        tests++; if (o_b_stall !== 1'b1) begin fails++; $display("FAIL a_alone_bstall_t3 got %b want 1", o_b_stall); end
        step();
        wb_ack = 0;
        #1;
        tests++; if (o_owner !== 2'd0 || o_wb_cyc !== 1'b0) begin fails++; $display("FAIL a_alone_release owner=%0d cyc=%b want 0 0", o_owner, o_wb_cyc); end
    endtask

    task automatic test_handover();
        do_reset();
        a_cyc = 1; a_stb = 1; a_addr = 30'h11;
        b_cyc = 1; b_stb = 1; b_addr = 30'h22;
        step();
        tests++; if (o_owner !== 2'd2 || o_wb_addr !== 30'h22) begin fails++; $display("FAIL tie_first owner=%0d addr=%0h want 2 22", o_owner, o_wb_addr); end
        b_cyc = 0; b_stb = 0;
        step();
        tests++; if (o_owner !== 2'd1 || o_wb_cyc !== 1'b1 || o_wb_addr !== 30'h11) begin fails++; $display("FAIL handover owner=%0d cyc=%b addr=%0h want 1 1 11", o_owner, o_wb_cyc, o_wb_addr); end
        a_cyc = 0; a_stb = 0;
        step();
        tests++; if (o_owner !== 2'd0) begin fails++; $display("FAIL handover_release owner=%0d want 0", o_owner); end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        for (int r = 0; r < 4; r++) begin
            a_cyc = 1; a_stb = 1; b_cyc = 1; b_stb = 1;
            step();
            tests++; if (f_owner !== 2'd2) begin fails++; $display("FAIL fp_tie round=%0d owner=%0d want 2", r, f_owner); end
            b_cyc = 0; b_stb = 0;
            step();
            tests++; if (f_owner !== 2'd1) begin fails++; $display("FAIL fp_a_after_b round=%0d owner=%0d want 1", r, f_owner); end
            a_cyc = 0; a_stb = 0;
            step();
        end
    endtask

    task automatic test_burst();
        int  issued = 0, acked = 0;
        bit  dl0 = 0, dl1 = 0, acc = 0, ack_now, done = 0, bbad = 0, dbad = 0;
        do_reset();
        a_cyc = 1; a_stb = 1; a_addr = 30'h2000;
        for (int c = 0; c < 300 && !done; c++) begin
            step();
            ack_now = dl1; dl1 = dl0; dl0 = acc;
            wb_ack = ack_now; wb_rdata = acked;
            a_stb = (issued < 32);
            if (c == 6) begin b_cyc = 1; b_stb = 1; end
            #1;
            acc = o_wb_stb && !o_a_stall;
            if (acc) issued++;
            if (o_a_ack) begin
                if (o_a_data !== 32'(acked)) dbad = 1;
                acked++;
            end
            if (b_cyc && (!o_b_stall || o_b_ack)) bbad = 1;
            if (acked == 32) done = 1;
        end
        tests++; if (!done || issued != 32) begin fails++; $display("FAIL burst_complete acked=%0d issued=%0d want 32 32", acked, issued); end
        tests++; if (bbad) begin fails++; $display("FAIL burst_b_stalled got unstalled want stalled"); end
        tests++; if (dbad) begin fails++; $display("FAIL burst_data got mismatched beat want in-order beats"); end
        step();
        wb_ack = 0;
        #1;
        tests++; if (dut.r_outstanding !== 4'd0 || o_owner !== 2'd1) begin fails++; $display("FAIL burst_drain outstanding=%0d owner=%0d want 0 1", dut.r_outstanding, o_owner); end
        a_cyc = 0; a_stb = 0;
        step();
        tests++; if (o_owner !== 2'd2) begin fails++; $display("FAIL burst_handover owner=%0d want 2", o_owner); end
        b_cyc = 0; b_stb = 0;
        step();
    endtask

    task automatic test_full();
        int accepted = 0;
        do_reset();
        a_cyc = 1; a_stb = 1;
        for (int c = 0; c < 16; c++) begin
            step();
            if (o_wb_stb && !o_a_stall) accepted++;
        end
        tests++; if (accepted != 15) begin fails++; $display("FAIL full_count got %0d want 15", accepted); end
        tests++; if (o_a_stall !== 1'b1 || o_wb_stb !== 1'b0) begin fails++; $display("FAIL full_stall stall=%b stb=%b want 1 0", o_a_stall, o_wb_stb); end
        a_cyc = 0; a_stb = 0;
        step();
        tests++; if (o_owner !== 2'd0) begin fails++; $display("FAIL full_release owner=%0d want 0", o_owner); end
    endtask

    task automatic test_timeout();
        int first = -1;
        do_reset();
        a_cyc = 1; a_stb = 1;
        step();
        tests++; if (o_wb_stb !== 1'b1) begin fails++; $display("FAIL to_stb got %b want 1", o_wb_stb); end
        for (int k = 1; k <= 40 && first < 0; k++) begin
            step();
            if (k == 1) a_stb = 0;
            #1;
            if (o_a_err || o_timeout) begin
                first = k;
                tests++; if (o_a_err !== 1'b1 || o_timeout !== 1'b1 || o_b_err !== 1'b0) begin fails++; $display("FAIL to_pulse aerr=%b to=%b berr=%b want 1 1 0", o_a_err, o_timeout, o_b_err); end
            end
        end
        tests++; if (first != 16) begin fails++; $display("FAIL to_latency got %0d want 16", first); end
        step();
        tests++; if (o_wb_cyc !== 1'b0 || o_timeout !== 1'b0 || o_a_err !== 1'b0 || o_a_stall !== 1'b1) begin fails++; $display("FAIL to_after cyc=%b to=%b err=%b stall=%b want 0 0 0 1", o_wb_cyc, o_timeout, o_a_err, o_a_stall); end
        b_cyc = 1; b_stb = 1;
        step();
        step();
        tests++; if (o_owner !== 2'd0 || o_wb_cyc !== 1'b0 || o_b_stall !== 1'b1) begin fails++; $display("FAIL to_abort_hold owner=%0d cyc=%b bstall=%b want 0 0 1", o_owner, o_wb_cyc, o_b_stall); end
        a_cyc = 0;
        step();
        step();
        tests++; if (o_owner !== 2'd2) begin fails++; $display("FAIL to_recover owner=%0d want 2", o_owner); end
        b_cyc = 0; b_stb = 0;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        b_cyc = 1; b_stb = 1;
        step();
        step();
        step();
        b_stb = 0;
        #1;
        tests++; if (dut.r_outstanding !== 4'd2) begin fails++; $display("FAIL rm_setup outstanding=%0d want 2", dut.r_outstanding); end
        rst = 1; wb_ack = 1;
        #1;
        tests++; if (o_b_ack !== 1'b0 || o_a_ack !== 1'b0) begin fails++; $display("FAIL rm_no_ack a=%b b=%b want 0 0", o_a_ack, o_b_ack); end
        step();
        rst = 0; wb_ack = 0;
        #1;
        tests++; if (o_wb_cyc !== 1'b0 || o_owner !== 2'd0 || dut.r_outstanding !== 4'd0) begin fails++; $display("FAIL rm_after cyc=%b owner=%0d outstanding=%0d want 0 0 0", o_wb_cyc, o_owner, dut.r_outstanding); end
        tests++; if (o_b_err !== 1'b0 || o_timeout !== 1'b0) begin fails++; $display("FAIL rm_no_err err=%b to=%b want 0 0", o_b_err, o_timeout); end
        b_cyc = 0;
        step();
    endtask

    task automatic test_random();
        int          sel, exp_rr, exp_fp, last_rr, lat;
        logic [29:0] aa, ba, exp_addr;
        logic [31:0] d;
        logic        w_ack, l_ack, l_stall;
        do_reset();
        last_rr = 1;
        for (int t = 0; t < 40; t++) begin
            sel = int'($urandom_range(1, 3));
            aa = 30'($urandom); ba = 30'($urandom);
            a_addr = aa; b_addr = ba;
            a_cyc = (sel & 1) != 0; a_stb = a_cyc;
            b_cyc = (sel & 2) != 0; b_stb = b_cyc;
            exp_rr = (sel == 3) ? ((last_rr == 1) ? 2 : 1) : sel;
            exp_fp = (sel == 3) ? 2 : sel;
            exp_addr = (exp_rr == 1) ? aa : ba;
            #1;
            tests++; if (o_owner !== 2'd0) begin fails++; $display("FAIL rnd_idle t=%0d owner=%0d want 0", t, o_owner); end
            step();
            tests++; if (o_owner !== 2'(exp_rr) || f_owner !== 2'(exp_fp)) begin fails++; $display("FAIL rnd_grant t=%0d rr=%0d fp=%0d want %0d %0d", t, o_owner, f_owner, exp_rr, exp_fp); end
            tests++; if (o_wb_addr !== exp_addr) begin fails++; $display("FAIL rnd_addr t=%0d got %0h want %0h", t, o_wb_addr, exp_addr); end
            last_rr = exp_rr;
            step();
            a_stb = 0; b_stb = 0;
            lat = int'($urandom_range(0, 2));
            repeat (lat) step();
            d = $urandom;
            wb_ack = 1; wb_rdata = d;
            #1;
            w_ack   = (exp_rr == 1) ? o_a_ack : o_b_ack;
            l_ack   = (exp_rr == 1) ? o_b_ack : o_a_ack;
            l_stall = (exp_rr == 1) ? o_b_stall : o_a_stall;
            tests++; if (w_ack !== 1'b1 || l_ack !== 1'b0 || l_stall !== 1'b1 || o_a_data !== d) begin fails++; $display("FAIL rnd_route t=%0d wack=%b lack=%b lstall=%b data=%0h want 1 0 1 %0h", t, w_ack, l_ack, l_stall, o_a_data, d); end
            step();
            wb_ack = 0; a_cyc = 0; b_cyc = 0;
            step();
            tests++; if (o_owner !== 2'd0 || f_owner !== 2'd0) begin fails++; $display("FAIL rnd_release t=%0d rr=%0d fp=%0d want 0 0", t, o_owner, f_owner); end
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_a_alone();
        test_handover();
        test_fixed_priority();
        test_burst();
        test_full();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
